// File: rtl/intf2_wr_sched_if.sv
// Handshake/bus bundle between the INTERFACE2 write-side scheduler and its surroundings.
// ERR / ERR_CLR exist only when INTF2_SCHED_ERR_EN is defined.
interface intf2_wr_sched_if #(
  parameter int AW = 4
);
  logic          START;
  logic          EXTN_VLD;
  logic          HRMF_VLD;
  logic          SEL_EXTN;
  logic [1:0]    SEL_PERMW;
  logic [AW-1:0] WADDR;
  logic          WE;
  logic [1:0]    STAGE;
  logic          STAGE_START;
  logic          BUSY;
  logic          DONE;
`ifdef INTF2_SCHED_ERR_EN
  logic          ERR;
  logic          ERR_CLR;

  modport master (
    output START, EXTN_VLD, HRMF_VLD, ERR_CLR,
    input  SEL_EXTN, SEL_PERMW, WADDR, WE, STAGE, STAGE_START, BUSY, DONE, ERR
  );
  modport slave (
    input  START, EXTN_VLD, HRMF_VLD, ERR_CLR,
    output SEL_EXTN, SEL_PERMW, WADDR, WE, STAGE, STAGE_START, BUSY, DONE, ERR
  );
`else
  modport master (
    output START, EXTN_VLD, HRMF_VLD,
    input  SEL_EXTN, SEL_PERMW, WADDR, WE, STAGE, STAGE_START, BUSY, DONE
  );
  modport slave (
    input  START, EXTN_VLD, HRMF_VLD,
    output SEL_EXTN, SEL_PERMW, WADDR, WE, STAGE, STAGE_START, BUSY, DONE
  );
`endif
endinterface

// File: rtl/intf2_wr_sched.sv
// Write-side scheduler for the 4-bank FFT memory: one LOAD phase then LOG4N butterfly stages.
// Optional sticky misuse flag (ERR/ERR_CLR) enabled by defining INTF2_SCHED_ERR_EN.
module intf2_wr_sched #(
  parameter int LOG4N = 3,
  parameter int AW    = 2*(LOG4N-1)
) (
  input  logic CLK,
  input  logic RSTN,
  intf2_wr_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STG, S_FIN} state_t;

  localparam logic [1:0] LAST_STAGE = 2'(LOG4N-1);

  state_t        state_q, state_d;
  logic [AW-1:0] g_q, g_d;
  logic [1:0]    stage_q, stage_d;
  logic [1:0]    perm_q;
  logic          ss_q, ss_d;
  logic          busy_q, done_q, sel_extn_q;
  logic          beat_ext, beat_hrmf, g_last;

  // Conflict-free rotation: base-4 digit sum of the beat index, modulo 4.
  function automatic logic [1:0] digit_sum(input logic [AW-1:0] g);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 0; i < AW/2; i++) s = s + g[2*i +: 2];
    return s;
  endfunction

  assign beat_ext  = (state_q == S_LOAD) && bus.EXTN_VLD;
  assign beat_hrmf = (state_q == S_STG)  && bus.HRMF_VLD;
  // N/4 = 2^AW, so the last beat of a phase is the all-ones index.
  assign g_last    = &g_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    stage_d = stage_q;
    ss_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_LOAD;
          g_d     = '0;
          stage_d = 2'd0;
        end
      end
      S_LOAD: begin
        if (beat_ext) begin
          if (g_last) begin
            state_d = S_STG;
            g_d     = '0;
            stage_d = 2'd0;
            ss_d    = 1'b1;
          end else begin
            g_d = g_q + AW'(1);
          end
        end
      end
      S_STG: begin
        if (beat_hrmf) begin
          if (g_last) begin
            g_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = S_FIN;
            end else begin
              stage_d = stage_q + 2'd1;
              ss_d    = 1'b1;
            end
          end else begin
            g_d = g_q + AW'(1);
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Rotation is registered from the next index so it is settled before the beat arrives.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      g_q        <= '0;
      perm_q     <= 2'd0;
      stage_q    <= 2'd0;
      ss_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_extn_q <= 1'b0;
    end else begin
      g_q        <= g_d;
      perm_q     <= digit_sum(g_d);
      stage_q    <= stage_d;
      ss_q       <= ss_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FIN);
      sel_extn_q <= (state_d == S_STG);
    end
  end

`ifdef INTF2_SCHED_ERR_EN
  logic err_q, err_set;

  assign err_set = (bus.EXTN_VLD && (state_q != S_LOAD)) ||
                   (bus.HRMF_VLD && (state_q != S_STG))  ||
                   (bus.START && busy_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)            err_q <= 1'b0;
    else if (bus.ERR_CLR) err_q <= 1'b0;
    else if (err_set)     err_q <= 1'b1;
  end

  assign bus.ERR = err_q;
`endif

  assign bus.SEL_EXTN    = sel_extn_q;
  assign bus.SEL_PERMW   = perm_q;
  assign bus.WADDR       = g_q;
  assign bus.WE          = beat_ext | beat_hrmf;
  assign bus.STAGE       = stage_q;
  assign bus.STAGE_START = ss_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;

endmodule

// File: tb/tb_intf2_wr_sched.sv
// Directed self-checking bench for intf2_wr_sched (LOG4N=3: 16 beats per phase, 3 stages).
module tb_intf2_wr_sched;
  localparam int AW = 4;

  logic CLK = 1'b0;
  logic RSTN;
  logic clr;
  int   tests = 0;
  int   fails = 0;
  int   we_cnt, ss_cnt, done_cnt, snap;
  logic [1:0] stage_seen [0:7];
  int         gi   [0:3] = '{0, 1, 5, 15};
  logic [1:0] pexp [0:3] = '{2'd0, 2'd1, 2'd2, 2'd2};

  intf2_wr_sched_if #(.AW(AW)) bus();
  intf2_wr_sched #(.LOG4N(3), .AW(AW)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (clr) begin
      we_cnt   <= 0;
      ss_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (bus.WE) we_cnt <= we_cnt + 1;
      if (bus.STAGE_START) begin
        if (ss_cnt < 8) stage_seen[ss_cnt] <= bus.STAGE;
        ss_cnt <= ss_cnt + 1;
      end
      if (bus.DONE) done_cnt <= done_cnt + 1;
    end
  end

  task automatic cyc(input logic start, input logic ext, input logic hrmf);
    @(negedge CLK);
    bus.START    = start;
    bus.EXTN_VLD = ext;
    bus.HRMF_VLD = hrmf;
  endtask

  task automatic clear_counts;
    cyc(1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
  endtask

  task automatic beats(input logic ext, input logic hrmf, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ext, hrmf);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 1'b0);
    beats(1'b1, 1'b0, 3);
    #1;
    tests++; if (bus.WADDR !== 4'd2 || bus.BUSY !== 1'b1) begin
      fails++; $display("FAIL pre_reset_state: got waddr=%0d busy=%0b want waddr=2 busy=1", bus.WADDR, bus.BUSY);
    end
    #2 RSTN = 1'b0;
    #1;
    tests++; if ({bus.SEL_EXTN, bus.SEL_PERMW, bus.WADDR, bus.WE, bus.STAGE, bus.STAGE_START, bus.BUSY, bus.DONE} !== 13'd0) begin
      fails++; $display("FAIL async_reset_outputs: got %0h want 0",
        {bus.SEL_EXTN, bus.SEL_PERMW, bus.WADDR, bus.WE, bus.STAGE, bus.STAGE_START, bus.BUSY, bus.DONE});
    end
    bus.EXTN_VLD = 1'b0;
    @(negedge CLK) RSTN = 1'b1;
    clear_counts;
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (we_cnt !== 0 || bus.BUSY !== 1'b0) begin
      fails++; $display("FAIL idle_hold: got we=%0d busy=%0b want we=0 busy=0", we_cnt, bus.BUSY);
    end
  endtask

  task automatic test_full;
    clear_counts;
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      #1;
      if (k == 0) begin
        tests++; if (bus.SEL_EXTN !== 1'b0 || bus.BUSY !== 1'b1 || bus.WE !== 1'b1) begin
          fails++; $display("FAIL load_entry: got sel=%0b busy=%0b we=%0b want 0 1 1", bus.SEL_EXTN, bus.BUSY, bus.WE);
        end
      end
      for (int j = 0; j < 4; j++) if (k == gi[j]) begin
        tests++; if ({bus.WADDR, bus.SEL_PERMW} !== {4'(gi[j]), pexp[j]}) begin
          fails++; $display("FAIL load_rot_g%0d: got waddr=%0d perm=%0d want waddr=%0d perm=%0d", gi[j], bus.WADDR, bus.SEL_PERMW, gi[j], pexp[j]);
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) begin
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        if (k == 0) begin
          tests++; if ({bus.SEL_EXTN, bus.STAGE_START, bus.STAGE} !== {2'b11, 2'(s)}) begin
            fails++; $display("FAIL stage%0d_entry: got sel=%0b ss=%0b stage=%0d want 1 1 %0d", s, bus.SEL_EXTN, bus.STAGE_START, bus.STAGE, s);
          end
        end
        if (s == 2) for (int j = 0; j < 4; j++) if (k == gi[j]) begin
          tests++; if ({bus.WADDR, bus.SEL_PERMW} !== {4'(gi[j]), pexp[j]}) begin
            fails++; $display("FAIL stg_rot_g%0d: got waddr=%0d perm=%0d want waddr=%0d perm=%0d", gi[j], bus.WADDR, bus.SEL_PERMW, gi[j], pexp[j]);
          end
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if ({bus.DONE, bus.BUSY} !== 2'b11) begin
      fails++; $display("FAIL fin_cycle: got done=%0b busy=%0b want 1 1", bus.DONE, bus.BUSY);
    end
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if ({bus.DONE, bus.BUSY, bus.SEL_EXTN} !== 3'b000) begin
      fails++; $display("FAIL after_done: got done=%0b busy=%0b sel=%0b want 0 0 0", bus.DONE, bus.BUSY, bus.SEL_EXTN);
    end
    tests++; if (we_cnt !== 64 || ss_cnt !== 3 || done_cnt !== 1) begin
      fails++; $display("FAIL full_counts: got we=%0d ss=%0d done=%0d want 64 3 1", we_cnt, ss_cnt, done_cnt);
    end
    tests++; if ({stage_seen[0], stage_seen[1], stage_seen[2]} !== 6'b00_01_10) begin
      fails++; $display("FAIL stage_seq: got %0d,%0d,%0d want 0,1,2", stage_seen[0], stage_seen[1], stage_seen[2]);
    end
`ifdef INTF2_SCHED_ERR_EN
    tests++; if (bus.ERR !== 1'b0) begin
      fails++; $display("FAIL err_clean_run: got %0b want 0", bus.ERR);
    end
`endif
  endtask

  task automatic test_gapped;
    clear_counts;
    cyc(1'b1, 1'b0, 1'b0);
    beats(1'b1, 1'b0, 16);
    beats(1'b0, 1'b1, 16);
    cyc(1'b0, 1'b0, 0);
    snap = we_cnt;
    for (int b = 0; b < 16; b++) begin
      if (b > 0) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      #1;
      if (b == 3) begin
        tests++; if (bus.WE !== 1'b0 || bus.WADDR !== 4'd3) begin
          fails++; $display("FAIL gap_hold: got we=%0b waddr=%0d want 0 3", bus.WE, bus.WADDR);
        end
      end
      if (b == 15) begin
        tests++; if (bus.STAGE !== 2'd1 || bus.WADDR !== 4'd15) begin
          fails++; $display("FAIL gap_last: got stage=%0d waddr=%0d want 1 15", bus.STAGE, bus.WADDR);
        end
      end
      cyc(1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.STAGE !== 2'd2 || bus.WADDR !== 4'd0 || (we_cnt - snap) !== 16) begin
      fails++; $display("FAIL gap_stage_end: got stage=%0d waddr=%0d beats=%0d want 2 0 16", bus.STAGE, bus.WADDR, we_cnt - snap);
    end
    beats(1'b0, 1'b1, 16);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (we_cnt !== 64 || done_cnt !== 1 || bus.BUSY !== 1'b0) begin
      fails++; $display("FAIL gap_complete: got we=%0d done=%0d busy=%0b want 64 1 0", we_cnt, done_cnt, bus.BUSY);
    end
  endtask

  task automatic test_misuse;
    clear_counts;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    #1;
    tests++; if (bus.WE !== 1'b0) begin
      fails++; $display("FAIL hrmf_in_load_we: got %0b want 0", bus.WE);
    end
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if ({bus.WADDR, bus.SEL_PERMW} !== 6'd0) begin
      fails++; $display("FAIL hrmf_in_load_cnt: got waddr=%0d perm=%0d want 0 0", bus.WADDR, bus.SEL_PERMW);
    end
    beats(1'b1, 1'b0, 16);
    beats(1'b0, 1'b1, 4);
    cyc(1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (bus.WE !== 1'b0) begin
      fails++; $display("FAIL start_in_stg_we: got %0b want 0", bus.WE);
    end
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if ({bus.WADDR, bus.STAGE, bus.BUSY, bus.SEL_EXTN} !== {4'd4, 2'd0, 2'b11}) begin
      fails++; $display("FAIL start_in_stg_state: got waddr=%0d stage=%0d busy=%0b sel=%0b want 4 0 1 1", bus.WADDR, bus.STAGE, bus.BUSY, bus.SEL_EXTN);
    end
    beats(1'b0, 1'b1, 12 + 32);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (we_cnt !== 64 || done_cnt !== 1) begin
      fails++; $display("FAIL misuse_complete: got we=%0d done=%0d want 64 1", we_cnt, done_cnt);
    end
`ifdef INTF2_SCHED_ERR_EN
    tests++; if (bus.ERR !== 1'b1) begin
      fails++; $display("FAIL err_sticky: got %0b want 1", bus.ERR);
    end
    @(negedge CLK) bus.ERR_CLR = 1'b1;
    @(negedge CLK) bus.ERR_CLR = 1'b0;
    #1;
    tests++; if (bus.ERR !== 1'b0) begin
      fails++; $display("FAIL err_clear: got %0b want 0", bus.ERR);
    end
`endif
  endtask

  task automatic test_abort;
    clear_counts;
    cyc(1'b1, 1'b0, 1'b0);
    beats(1'b1, 1'b0, 16);
    beats(1'b0, 1'b1, 16 + 7);
    cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.STAGE !== 2'd1 || bus.WADDR !== 4'd7) begin
      fails++; $display("FAIL abort_point: got stage=%0d waddr=%0d want 1 7", bus.STAGE, bus.WADDR);
    end
    #2 RSTN = 1'b0;
    #1;
    tests++; if ({bus.BUSY, bus.WADDR, bus.STAGE, bus.SEL_EXTN, bus.SEL_PERMW} !== 10'd0 || done_cnt !== 0) begin
      fails++; $display("FAIL abort_reset: got busy=%0b waddr=%0d stage=%0d done=%0d want all 0", bus.BUSY, bus.WADDR, bus.STAGE, done_cnt);
    end
    @(negedge CLK) RSTN = 1'b1;
    clear_counts;
    cyc(1'b1, 1'b0, 1'b0);
    beats(1'b1, 1'b0, 16);
    beats(1'b0, 1'b1, 48);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (we_cnt !== 64 || done_cnt !== 1 || ss_cnt !== 3 || bus.BUSY !== 1'b0) begin
      fails++; $display("FAIL rerun_after_abort: got we=%0d done=%0d ss=%0d busy=%0b want 64 1 3 0", we_cnt, done_cnt, ss_cnt, bus.BUSY);
    end
  endtask

  initial begin
    RSTN         = 1'b0;
    clr          = 1'b1;
    bus.START    = 1'b0;
    bus.EXTN_VLD = 1'b0;
    bus.HRMF_VLD = 1'b0;
`ifdef INTF2_SCHED_ERR_EN
    bus.ERR_CLR  = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    clr  = 1'b0;
    test_reset;
    test_full;
    test_gapped;
    test_misuse;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intf2_wr_sched.md
Name: intf2_wr_sched

Overview:
- Write-side scheduler for the 4-bank FFT working memory fed through INTERFACE2.
- Sequences one transform: one LOAD phase (external samples, SEL_EXTN=0), then LOG4N butterfly stages (HRMF results, SEL_EXTN=1).
- Per accepted beat it drives SEL_PERMW (conflict-free bank rotation), the bank word address and the write enable.
- Reports stage boundaries to the read side and signals completion.

Parameters:
- LOG4N, 3, log4 of FFT size; N = 4^LOG4N points, N/4 beats per phase (default 64 points, 16 beats).
- AW, 2*(LOG4N-1), bank word address width (default 4).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  pulse; begins a transform when in IDLE, ignored elsewhere.
- EXTN_VLD  in  1  external 4-sample beat present on D*_EXTN this cycle.
- HRMF_VLD  in  1  butterfly-result beat present on D*_HRMF this cycle.
- SEL_EXTN  out  1  INTERFACE2 source select (0 = EXTN, 1 = HRMF).
- SEL_PERMW  out  2  INTERFACE2 rotation select.
- WADDR  out  AW  bank word address, common to all 4 banks.
- WE  out  1  bank write enable.
- STAGE  out  2  current stage index 0..LOG4N-1, valid in STG.
- STAGE_START  out  1  one-cycle pulse at entry of each stage (tells the read side to start issuing).
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse after the last beat of the last stage.

Behaviour:
- Reset (async, RSTN=0): state IDLE, beat counter G=0, STAGE=0. SEL_EXTN, SEL_PERMW, WADDR, STAGE_START, BUSY and DONE are all 0. WE=0.
- States: IDLE, LOAD, STG, FIN.
  - IDLE: START=1 -> LOAD; BUSY=1 next cycle; G=0.
  - LOAD: each EXTN_VLD beat writes and increments G. The beat with G=N/4-1 -> STG, G=0, STAGE=0, STAGE_START=1 in the first STG cycle.
  - STG: each HRMF_VLD beat writes and increments G. The beat with G=N/4-1:
    - if STAGE<LOG4N-1: STAGE+1, G=0, stay in STG, STAGE_START pulses the next cycle;
    - else -> FIN.
  - FIN: one cycle; DONE=1, BUSY=0 next cycle, -> IDLE.
- SEL_EXTN is a registered decode of state: 1 in STG, 0 otherwise.
- WADDR = G (registered).
- SEL_PERMW = (sum of the base-4 digits of G) mod 4. It is registered and updated together with G, so it is stable before the beat arrives.
- WE is combinational, asserted the same cycle as the beat: (LOAD & EXTN_VLD) | (STG & HRMF_VLD). Zero-cycle latency from VLD to WE.
- Counter G wraps N/4-1 -> 0 only on phase end; it never free-runs. No beat means no advance; gaps of any length are legal.
- Valid in the wrong state (HRMF_VLD in LOAD/IDLE/FIN, EXTN_VLD in STG/IDLE/FIN) is ignored: no WE, no counter change.
- START while BUSY is ignored.
- Reset mid-transform aborts immediately to the reset values; no DONE is produced.
- EXTN_VLD and HRMF_VLD both high: only the one matching the state counts.

Optional Feature:
- Macro INTF2_SCHED_ERR_EN.
- Defined: adds output ERR (1 bit) and input ERR_CLR (1 bit).
  - ERR is a sticky flag set by any wrongly-timed valid: a valid in the wrong state, or START while BUSY.
  - ERR is cleared by ERR_CLR or by reset; ERR_CLR wins over a simultaneous set.
- Undefined: neither port exists; wrongly-timed events are silently ignored.

Test Plan (LOG4N=3):
- Reset then idle: RSTN low mid-cycle -> all outputs 0 immediately; START held 0 -> state stays IDLE, WE never rises.
- Full transform with continuous valids: START, 16 EXTN_VLD, then 3x16 HRMF_VLD -> 64 WE pulses, SEL_EXTN 0 then 1, three STAGE_START pulses with STAGE=0,1,2, single DONE, BUSY low after DONE.
- Rotation values: during any phase, at G=0,1,5,15 -> SEL_PERMW=0,1,2,2 and WADDR=0,1,5,15.
- Gapped valids: HRMF_VLD every 3rd cycle in stage 1 -> G advances only on valid cycles, WE only on valid cycles, stage ends after exactly 16 beats.
- Misuse: HRMF_VLD during LOAD and START during STG -> no WE, counters unchanged, transform completes normally; with INTF2_SCHED_ERR_EN, ERR=1 until ERR_CLR.
- Abort: RSTN asserted at stage 1, G=7 -> IDLE; a new START runs a full transform with a correct beat count and one DONE.
